// File: rtl/fifo_wr_rr_arbiter.sv
// Round-robin arbiter sharing one prefetch FIFO write port among NUM_REQ
// producers; each grant is a bounded burst released on last, length or idle.
module fifo_wr_rr_arbiter #(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned BURST_LEN    = 16,
    parameter int unsigned IDLE_TIMEOUT = 8,
    parameter int unsigned ID_W         = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_last,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          fifo_wr_en,
    output logic [DATA_WIDTH-1:0]         fifo_wr_data,
    input  logic                          fifo_wr_vld,
    output logic [ID_W-1:0]               grant_id,
    output logic                          busy,
    output logic                          burst_done
);

    localparam int unsigned BEAT_W = $clog2(BURST_LEN + 1);
    localparam int unsigned IDLE_W = $clog2(IDLE_TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BURST   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic [ID_W-1:0]   grant_nxt;
    logic [ID_W-1:0]   last_gnt, last_gnt_nxt;
    logic [BEAT_W-1:0] beat_cnt, beat_cnt_nxt, beat_inc;
    logic [IDLE_W-1:0] idle_cnt, idle_cnt_nxt, idle_inc;

    logic [DATA_WIDTH-1:0] req_data_arr [NUM_REQ];
    logic                  gnt_valid;
    logic                  gnt_last;
    logic [DATA_WIDTH-1:0] gnt_data;
    logic                  rel;

    logic            sel_found;
    logic [ID_W-1:0] sel_idx;
    logic [ID_W-1:0] cand_idx;
    int              cand;

    // Unpack the flat data bus into one word per requester.
    always_comb begin
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            req_data_arr[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Signals of the currently granted requester.
    always_comb begin
        gnt_valid = req_valid[grant_id];
        gnt_last  = req_last[grant_id];
        gnt_data  = req_data_arr[grant_id];
    end

    // Round-robin pick: first valid requester after last_gnt, wrapping.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = 0;
        cand_idx  = '0;
        for (int i = 1; i <= int'(NUM_REQ); i++) begin
            cand = int'(last_gnt) + i;
            if (cand >= int'(NUM_REQ)) begin
                cand = cand - int'(NUM_REQ);
            end
            cand_idx = ID_W'(cand);
            if (!sel_found && req_valid[cand_idx]) begin
                sel_found = 1'b1;
                sel_idx   = cand_idx;
            end
        end
    end

    // State, grant, pointer and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            grant_id <= '0;
            last_gnt <= ID_W'(NUM_REQ - 1);
            beat_cnt <= '0;
            idle_cnt <= '0;
        end else begin
            state    <= state_nxt;
            grant_id <= grant_nxt;
            last_gnt <= last_gnt_nxt;
            beat_cnt <= beat_cnt_nxt;
            idle_cnt <= idle_cnt_nxt;
        end
    end

    // Next-state, counters and the pass-through write port.
    always_comb begin
        state_nxt    = state;
        grant_nxt    = grant_id;
        last_gnt_nxt = last_gnt;
        beat_cnt_nxt = beat_cnt;
        idle_cnt_nxt = idle_cnt;
        beat_inc     = beat_cnt + BEAT_W'(1);
        idle_inc     = idle_cnt + IDLE_W'(1);
        rel          = 1'b0;
        req_ready    = '0;
        fifo_wr_en   = 1'b0;
        fifo_wr_data = '0;
        busy         = 1'b0;
        burst_done   = 1'b0;

        case (state)
            IDLE: begin
                if (sel_found) begin
                    grant_nxt = sel_idx;
                    state_nxt = BURST;
                end
            end

            BURST: begin
                busy                = 1'b1;
                req_ready[grant_id] = fifo_wr_vld;
                fifo_wr_en          = gnt_valid & fifo_wr_vld;
                fifo_wr_data        = gnt_data;
                if (gnt_valid) begin
                    idle_cnt_nxt = '0;
                end
                // A stalled FIFO freezes both counters.
                if (fifo_wr_en) begin
                    beat_cnt_nxt = beat_inc;
                    if (gnt_last || (beat_inc == BEAT_W'(BURST_LEN))) begin
                        rel = 1'b1;
                    end
                end else if (fifo_wr_vld && !gnt_valid) begin
                    idle_cnt_nxt = idle_inc;
                    if (idle_inc == IDLE_W'(IDLE_TIMEOUT)) begin
                        rel = 1'b1;
                    end
                end
                if (rel) begin
                    state_nxt    = RELEASE;
                    last_gnt_nxt = grant_id;
                    beat_cnt_nxt = '0;
                    idle_cnt_nxt = '0;
                end
            end

            RELEASE: begin
                burst_done = 1'b1;
                state_nxt  = IDLE;
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_fifo_wr_rr_arbiter.sv
// Directed self-checking bench for fifo_wr_rr_arbiter with a small producer model.
module tb_fifo_wr_rr_arbiter;

    localparam int NR = 4;
    localparam int DW = 32;
    localparam int IW = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic [NR-1:0]     req_valid = '0;
    logic [NR-1:0]     req_last = '0;
    logic [NR*DW-1:0]  req_data = '0;
    logic [NR-1:0]     req_ready;
    logic              fifo_wr_en;
    logic [DW-1:0]     fifo_wr_data;
    logic              fifo_wr_vld = 1'b1;
    logic [IW-1:0]     grant_id;
    logic              busy;
    logic              burst_done;

    fifo_wr_rr_arbiter #(
        .NUM_REQ(4), .DATA_WIDTH(32), .BURST_LEN(16), .IDLE_TIMEOUT(8), .ID_W(2)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_last(req_last), .req_data(req_data),
        .req_ready(req_ready),
        .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data), .fifo_wr_vld(fifo_wr_vld),
        .grant_id(grant_id), .busy(busy), .burst_done(burst_done)
    );

    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;

    // Producer model: enable, beats sent, beat limit, req_last period (0 = never).
    logic [NR-1:0] en;
    int cnt [NR];
    int lim [NR];
    int lp [NR];

    // Per-test observations.
    int wr_cnt [NR];
    int cyc, first_wr_cyc, last_wr_cyc, last_wr_done, done_cnt, inv_err, beats_in_burst;
    int gnt_q[$];
    int beats_q[$];
    int gap_q[$];
    int exp_q[$];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic check_list(input string tag, input int q[$], input int e[$]);
        int v;
        check($sformatf("%s size", tag), 32'(q.size()), 32'(e.size()));
        for (int i = 0; i < e.size(); i++) begin
            v = (i < q.size()) ? q[i] : -1;
            check($sformatf("%s[%0d]", tag, i), 32'(v), 32'(e[i]));
        end
    endtask

    function automatic logic [DW-1:0] word(input int r, input int c);
        return {8'(r), 24'(c)};
    endfunction

    task automatic new_test();
        en = '0;
        for (int i = 0; i < NR; i++) begin
            cnt[i] = 0; lim[i] = 0; lp[i] = 0; wr_cnt[i] = 0;
        end
        gnt_q.delete(); beats_q.delete(); gap_q.delete();
        cyc = 0; first_wr_cyc = -1; last_wr_cyc = -1; last_wr_done = 0;
        done_cnt = 0; inv_err = 0; beats_in_burst = 0;
    endtask

    task automatic drive();
        logic v;
        for (int i = 0; i < NR; i++) begin
            v = en[i] && (cnt[i] < lim[i]);
            req_valid[i] = v;
            req_last[i]  = v && (lp[i] != 0) && (((cnt[i] + 1) % (lp[i] == 0 ? 1 : lp[i])) == 0);
            req_data[i*DW +: DW] = word(i, cnt[i]);
        end
    endtask

    task automatic sample();
        logic [NR-1:0] hs;
        int k;
        hs = req_valid & req_ready;
        k = -1;
        for (int i = 0; i < NR; i++) if (hs[i]) k = i;
        if ($countones(hs) > 1) inv_err++;
        if (fifo_wr_en != (hs != '0)) inv_err++;
        if (!fifo_wr_vld && (fifo_wr_en || req_ready != '0)) inv_err++;
        if (!busy && (fifo_wr_en || req_ready != '0)) inv_err++;
        if (fifo_wr_en && k >= 0) begin
            if (fifo_wr_data != word(k, cnt[k])) inv_err++;
            if (first_wr_cyc < 0) first_wr_cyc = cyc;
            if (last_wr_cyc >= 0 && done_cnt != last_wr_done) gap_q.push_back(cyc - last_wr_cyc);
            last_wr_cyc  = cyc;
            last_wr_done = done_cnt;
            cnt[k]++;
            wr_cnt[k]++;
            beats_in_burst++;
        end
        if (burst_done) begin
            gnt_q.push_back(int'(grant_id));
            beats_q.push_back(beats_in_burst);
            beats_in_burst = 0;
            done_cnt++;
        end
        cyc++;
    endtask

    task automatic cycle();
        drive();
        @(negedge clk);
        sample();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, " wr_en"}, 32'(fifo_wr_en), 0);
        check({tag, " ready"}, 32'(req_ready), 0);
        check({tag, " data"}, fifo_wr_data, 0);
        check({tag, " gid"}, 32'(grant_id), 0);
        check({tag, " busy"}, 32'(busy), 0);
        check({tag, " done"}, 32'(burst_done), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        new_test();
        #2 rst_n = 1'b0;
        #1 check_idle_outputs("reset");
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // T1: all four streaming, last on every 3rd beat; requester 0 has a second packet.
        new_test();
        en = 4'b1111;
        lim[0] = 6; lim[1] = 3; lim[2] = 3; lim[3] = 3;
        for (int i = 0; i < NR; i++) lp[i] = 3;
        run(35);
        exp_q = '{0, 1, 2, 3, 0};
        check_list("t1 grant", gnt_q, exp_q);
        exp_q = '{3, 3, 3, 3, 3};
        check_list("t1 beats", beats_q, exp_q);
        exp_q = '{3, 3, 3, 3};
        check_list("t1 gap", gap_q, exp_q);
        check("t1 first_wr", 32'(first_wr_cyc), 1);
        check("t1 done", 32'(done_cnt), 5);
        check("t1 inv", 32'(inv_err), 0);

        // T2: requester 2 alone with no last -> BURST_LEN cut, regrant, idle timeout.
        new_test();
        en[2] = 1'b1; lim[2] = 20;
        run(40);
        exp_q = '{2, 2};
        check_list("t2 grant", gnt_q, exp_q);
        exp_q = '{16, 4};
        check_list("t2 beats", beats_q, exp_q);
        exp_q = '{3};
        check_list("t2 gap", gap_q, exp_q);
        check("t2 wr", 32'(wr_cnt[2]), 20);
        check("t2 inv", 32'(inv_err), 0);

        // T3: requester 1 sends 5 then goes quiet, 3 waiting -> timeout then 3.
        new_test();
        en[1] = 1'b1; lim[1] = 5;
        cycle();
        en[3] = 1'b1; lim[3] = 3; lp[3] = 3;
        run(30);
        exp_q = '{1, 3};
        check_list("t3 grant", gnt_q, exp_q);
        exp_q = '{5, 3};
        check_list("t3 beats", beats_q, exp_q);
        exp_q = '{11};
        check_list("t3 gap", gap_q, exp_q);
        check("t3 wr1", 32'(wr_cnt[1]), 5);
        check("t3 inv", 32'(inv_err), 0);

        // T4: 20-cycle FIFO stall mid-burst, requester silent for half of it.
        new_test();
        en[0] = 1'b1; lim[0] = 10; lp[0] = 10;
        run(5);
        check("t4 pre_stall", 32'(wr_cnt[0]), 4);
        fifo_wr_vld = 1'b0;
        run(10);
        en[0] = 1'b0;
        run(10);
        check("t4 stall_wr", 32'(wr_cnt[0]), 4);
        check("t4 stall_busy", 32'(busy), 1);
        check("t4 stall_done", 32'(done_cnt), 0);
        en[0] = 1'b1;
        fifo_wr_vld = 1'b1;
        run(15);
        exp_q = '{0};
        check_list("t4 grant", gnt_q, exp_q);
        exp_q = '{10};
        check_list("t4 beats", beats_q, exp_q);
        check("t4 inv", 32'(inv_err), 0);

        // T5: fairness with last_gnt = 3 and requests from 0 and 3.
        new_test();
        en[3] = 1'b1; lim[3] = 1; lp[3] = 1;
        run(6);
        exp_q = '{3};
        check_list("t5 setup", gnt_q, exp_q);
        new_test();
        en[0] = 1'b1; lim[0] = 2; lp[0] = 2;
        en[3] = 1'b1; lim[3] = 1; lp[3] = 1;
        run(15);
        exp_q = '{0, 3};
        check_list("t5 grant", gnt_q, exp_q);
        check("t5 inv", 32'(inv_err), 0);

        // T6: reset while requester 1 presents its 7th beat; pointer returns to 0 first.
        new_test();
        en[0] = 1'b1; lim[0] = 1; lp[0] = 1;
        en[1] = 1'b1; lim[1] = 20;
        for (int n = 0; n < 40 && wr_cnt[1] < 6; n++) cycle();
        check("t6 reach", 32'(wr_cnt[1]), 6);
        drive();
        #2 check("t6 beat7_en", 32'(fifo_wr_en), 1);
        rst_n = 1'b0;
        #1 check_idle_outputs("t6 rst");
        @(posedge clk);
        #1 run(2);
        check("t6 no_wr", 32'(wr_cnt[1]), 6);
        check("t6 inv_pre", 32'(inv_err), 0);
        rst_n = 1'b1;
        new_test();
        en[0] = 1'b1; lim[0] = 2; lp[0] = 2;
        en[1] = 1'b1; lim[1] = 2; lp[1] = 2;
        run(15);
        exp_q = '{0, 1};
        check_list("t6 grant", gnt_q, exp_q);
        check("t6 inv", 32'(inv_err), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
